// File: rtl/pipe_hazard_sequencer_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding and control-unit opcodes.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STALL  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    localparam logic [4:0] OP_LD   = 5'b10110;
    localparam logic [4:0] OP_HALT = 5'b11010;

endpackage

// File: rtl/pipe_hazard_sequencer_if.sv
// ID/EX control fields in, pipeline enables/strobes and debug counters out.
interface pipe_hazard_sequencer_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic             start_req;
    logic             id_valid;
    logic [REG_W-1:0] id_read_reg0;
    logic [REG_W-1:0] id_read_reg1;
    logic [REG_W-1:0] id_write_reg;
    logic             id_write;
    logic             id_mem_to_reg;
    logic             id_halt;
    logic             ex_branch_taken;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output start_req, id_valid, id_read_reg0, id_read_reg1, id_write_reg,
               id_write, id_mem_to_reg, id_halt, ex_branch_taken,
        input  pc_en, ifid_en, ifid_flush, idex_flush, busy, halted,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  start_req, id_valid, id_read_reg0, id_read_reg1, id_write_reg,
               id_write, id_mem_to_reg, id_halt, ex_branch_taken,
        output pc_en, ifid_en, ifid_flush, idex_flush, busy, halted,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_sequencer_sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Pipeline sequencer: load-use stalls, taken-branch flushes and halt drain for the 5-stage CPU.
//   state  | meaning
//   IDLE   | not started; pipe held empty
//   RUN    | fetching; resolves branch > halt > load-use hazard
//   STALL  | extra load-use bubbles beyond the first
//   DRAIN  | halt seen in ID; waiting for EX/MEM/WB to empty
//   HALTED | pipe empty; only reset leaves
module pipe_hazard_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W          = 4,
    parameter int LOAD_USE_STALL = 1,
    parameter int DRAIN_CYCLES   = 3,
    parameter int CNT_W          = 16
) (
    input logic                    clk,
    input logic                    reset,
    pipe_hazard_sequencer_if.slave bus
);
    localparam int STALL_W = (LOAD_USE_STALL > 1) ? $clog2(LOAD_USE_STALL) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [STALL_W-1:0] stall_ctr_q, stall_ctr_d;
    logic [DRAIN_W-1:0] drain_ctr_q, drain_ctr_d;
    logic [REG_W-1:0]   ex_wr_q, ex_wr_d;
    logic               ex_load_q, ex_load_d;

    logic pc_en, ifid_en, ifid_flush, idex_flush;
    logic stall_inc, flush_inc, hazard;

    // Both read fields are compared even if the instruction uses only one.
    assign hazard = bus.id_valid & ex_load_q &
                    ((ex_wr_q == bus.id_read_reg0) | (ex_wr_q == bus.id_read_reg1));

    always_comb begin
        state_d     = state_q;
        stall_ctr_d = stall_ctr_q;
        drain_ctr_d = drain_ctr_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (bus.start_req) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.ex_branch_taken) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                end else if (bus.id_valid && bus.id_halt) begin
                    idex_flush  = 1'b1;
                    drain_ctr_d = DRAIN_W'(DRAIN_CYCLES - 1);
                    state_d     = ST_DRAIN;
                end else if (hazard) begin
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                    if (LOAD_USE_STALL > 1) begin
                        stall_ctr_d = STALL_W'(LOAD_USE_STALL - 2);
                        state_d     = ST_STALL;
                    end
                end else begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end
            end
            ST_STALL: begin
                idex_flush  = 1'b1;
                stall_inc   = 1'b1;
                stall_ctr_d = stall_ctr_q - STALL_W'(1);
                if (stall_ctr_q == '0) state_d = ST_RUN;
            end
            ST_DRAIN: begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                drain_ctr_d = drain_ctr_q - DRAIN_W'(1);
                if (drain_ctr_q == '0) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A bubble entering ID/EX keeps the old destination but can never be a load.
        ex_wr_d   = idex_flush ? ex_wr_q : bus.id_write_reg;
        ex_load_d = ~idex_flush & bus.id_valid & bus.id_write & bus.id_mem_to_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            stall_ctr_q <= '0;
            drain_ctr_q <= '0;
            ex_wr_q     <= '0;
            ex_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_ctr_q <= stall_ctr_d;
            drain_ctr_q <= drain_ctr_d;
            ex_wr_q     <= ex_wr_d;
            ex_load_q   <= ex_load_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (stall_inc),
        .count (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (flush_inc),
        .count (bus.flush_cnt)
    );

    assign bus.pc_en      = pc_en;
    assign bus.ifid_en    = ifid_en;
    assign bus.ifid_flush = ifid_flush;
    assign bus.idex_flush = idex_flush;
    assign bus.busy       = (state_q == ST_RUN) || (state_q == ST_STALL) || (state_q == ST_DRAIN);
    assign bus.halted     = (state_q == ST_HALTED);
endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed bench: one sequencer with a single load-use bubble, one with three, same stimulus.
module tb_pipe_hazard_sequencer;
    import pipe_ctrl_pkg::*;

    localparam logic [4:0] OP_ADD = 5'b00001;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic       sat_clr;
    logic       sat_inc;
    logic [2:0] sat_count;

    pipe_hazard_sequencer_if #(.REG_W(4), .CNT_W(16)) bus1 ();
    pipe_hazard_sequencer_if #(.REG_W(4), .CNT_W(16)) bus3 ();

    always #5 clk = ~clk;

    pipe_hazard_sequencer #(.REG_W(4), .LOAD_USE_STALL(1), .DRAIN_CYCLES(3), .CNT_W(16)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    pipe_hazard_sequencer #(.REG_W(4), .LOAD_USE_STALL(3), .DRAIN_CYCLES(3), .CNT_W(16)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    sat_counter #(.W(3)) u_sat (
        .clk   (clk),
        .clr   (sat_clr),
        .inc   (sat_inc),
        .count (sat_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [3:0] rd,
                         input logic [3:0] rs0, input logic [3:0] rs1, input logic br);
        bus1.id_valid        = v;
        bus1.id_write_reg    = rd;
        bus1.id_read_reg0    = rs0;
        bus1.id_read_reg1    = rs1;
        bus1.id_write        = (op == OP_LD) || (op == OP_ADD);
        bus1.id_mem_to_reg   = (op == OP_LD);
        bus1.id_halt         = (op == OP_HALT);
        bus1.ex_branch_taken = br;
        bus3.id_valid        = bus1.id_valid;
        bus3.id_write_reg    = rd;
        bus3.id_read_reg0    = rs0;
        bus3.id_read_reg1    = rs1;
        bus3.id_write        = bus1.id_write;
        bus3.id_mem_to_reg   = bus1.id_mem_to_reg;
        bus3.id_halt         = bus1.id_halt;
        bus3.ex_branch_taken = br;
    endtask

    task automatic set_start(input logic s);
        bus1.start_req = s;
        bus3.start_req = s;
    endtask

    initial begin
        reset   = 1'b1;
        sat_clr = 1'b1;
        sat_inc = 1'b0;
        set_start(1'b0);
        drive(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        // reset state
        sample();
        check("rst_pc_en", int'(bus1.pc_en), 0);
        check("rst_ifid_flush", int'(bus1.ifid_flush), 1);
        check("rst_idex_flush", int'(bus1.idex_flush), 1);
        check("rst_busy", int'(bus1.busy), 0);
        check("rst_halted", int'(bus1.halted), 0);
        check("rst_stall_cnt", int'(bus1.stall_cnt), 0);

        // 1: four independent adds
        set_start(1'b1);
        tick();
        set_start(1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, OP_ADD, 4'(i + 4), 4'(i + 8), 4'(i + 9), 1'b0);
            sample();
            check("t1_pc_en", int'(bus1.pc_en), 1);
            check("t1_ifid_en", int'(bus1.ifid_en), 1);
            check("t1_idex_flush", int'(bus1.idex_flush), 0);
            tick();
        end
        sample();
        check("t1_busy", int'(bus1.busy), 1);
        check("t1_stall_cnt", int'(bus1.stall_cnt), 0);
        check("t1_flush_cnt", int'(bus1.flush_cnt), 0);

        // 2/3: ld r2 then add reading r2
        drive(1'b1, OP_LD, 4'd2, 4'd1, 4'd0, 1'b0);
        sample();
        check("t2_ld_pc_en", int'(bus1.pc_en), 1);
        tick();
        drive(1'b1, OP_ADD, 4'd3, 4'd2, 4'd1, 1'b0);
        sample();
        check("t2_haz_pc_en", int'(bus1.pc_en), 0);
        check("t2_haz_idex_flush", int'(bus1.idex_flush), 1);
        check("t2_haz_ifid_flush", int'(bus1.ifid_flush), 0);
        check("t3_haz_pc_en", int'(bus3.pc_en), 0);
        tick();
        sample();
        check("t2_resume_pc_en", int'(bus1.pc_en), 1);
        check("t2_stall_cnt", int'(bus1.stall_cnt), 1);
        check("t3_stall2_pc_en", int'(bus3.pc_en), 0);
        check("t3_stall2_busy", int'(bus3.busy), 1);
        check("t3_stall_cnt_a", int'(bus3.stall_cnt), 1);
        tick();
        sample();
        check("t3_stall3_pc_en", int'(bus3.pc_en), 0);
        check("t3_stall_cnt_b", int'(bus3.stall_cnt), 2);
        tick();
        sample();
        check("t3_resume_pc_en", int'(bus3.pc_en), 1);
        check("t3_stall_cnt", int'(bus3.stall_cnt), 3);
        check("t2_stall_cnt_hold", int'(bus1.stall_cnt), 1);
        tick();

        // 4: branch squashes a load-use consumer
        drive(1'b1, OP_LD, 4'd5, 4'd0, 4'd0, 1'b0);
        tick();
        drive(1'b1, OP_ADD, 4'd6, 4'd5, 4'd5, 1'b1);
        sample();
        check("t4_pc_en", int'(bus1.pc_en), 1);
        check("t4_ifid_flush", int'(bus1.ifid_flush), 1);
        check("t4_idex_flush", int'(bus1.idex_flush), 1);
        tick();
        drive(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0);
        sample();
        check("t4_flush_cnt", int'(bus1.flush_cnt), 1);
        check("t4_stall_cnt", int'(bus1.stall_cnt), 1);
        check("t4_stall_cnt3", int'(bus3.stall_cnt), 3);
        check("t4_run_pc_en", int'(bus1.pc_en), 1);
        tick();

        // 5: halt drains three cycles, then HALTED ignores start_req
        drive(1'b1, OP_HALT, 4'd0, 4'd0, 4'd0, 1'b0);
        sample();
        check("t5_halt_pc_en", int'(bus1.pc_en), 0);
        check("t5_halt_idex_flush", int'(bus1.idex_flush), 1);
        check("t5_halt_ifid_flush", int'(bus1.ifid_flush), 0);
        tick();
        drive(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            sample();
            check("t5_drain_busy", int'(bus1.busy), 1);
            check("t5_drain_halted", int'(bus1.halted), 0);
            check("t5_drain_pc_en", int'(bus1.pc_en), 0);
            check("t5_drain_ifid_flush", int'(bus1.ifid_flush), 1);
            tick();
        end
        sample();
        check("t5_halted", int'(bus1.halted), 1);
        check("t5_halted_busy", int'(bus1.busy), 0);
        check("t5_halted3", int'(bus3.halted), 1);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        sample();
        check("t5_start_ignored", int'(bus1.halted), 1);
        check("t5_start_pc_en", int'(bus1.pc_en), 0);

        // 6: branch beats halt; reset during drain
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        drive(1'b1, OP_LD, 4'd7, 4'd0, 4'd0, 1'b0);
        tick();
        drive(1'b1, OP_HALT, 4'd0, 4'd7, 4'd7, 1'b1);
        sample();
        check("t6_br_pc_en", int'(bus1.pc_en), 1);
        check("t6_br_ifid_flush", int'(bus1.ifid_flush), 1);
        tick();
        drive(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0);
        sample();
        check("t6_no_drain_pc_en", int'(bus1.pc_en), 1);
        check("t6_no_drain_busy", int'(bus1.busy), 1);
        check("t6_flush_cnt", int'(bus1.flush_cnt), 1);
        tick();
        drive(1'b1, OP_HALT, 4'd0, 4'd0, 4'd0, 1'b0);
        tick();
        drive(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0);
        sample();
        check("t6_drain_ifid_flush", int'(bus1.ifid_flush), 1);
        check("t6_drain_pc_en", int'(bus1.pc_en), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sample();
        check("t6_rst_busy", int'(bus1.busy), 0);
        check("t6_rst_halted", int'(bus1.halted), 0);
        check("t6_rst_flush_cnt", int'(bus1.flush_cnt), 0);
        check("t6_rst_flush_cnt3", int'(bus3.flush_cnt), 0);
        check("t6_rst_stall_cnt3", int'(bus3.stall_cnt), 0);
        check("t6_rst_idex_flush", int'(bus1.idex_flush), 1);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        drive(1'b1, OP_ADD, 4'd1, 4'd0, 4'd0, 1'b0);
        sample();
        check("t6_rst_ex_clear", int'(bus1.pc_en), 1);
        tick();

        // saturation on a 3-bit counter
        sat_clr = 1'b0;
        sat_inc = 1'b1;
        repeat (6) tick();
        sample();
        check("sat_count6", int'(sat_count), 6);
        repeat (3) tick();
        sample();
        check("sat_hold7", int'(sat_count), 7);
        sat_inc = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
